// File: rtl/score_keeper.sv
// score_keeper: buffered score digit with frame-paced count-up and IDLE/PLAY/WON state; WIN_FLASH_EN adds win flashing
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int COUNT_DIV    = 4,
  parameter int MAX_PENDING  = 15,
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       hit,
  input  logic [1:0] hitPoints,
  output logic [3:0] score,
  output logic       busy,
  output logic       win,
  output logic       scoreVisible
);
  typedef enum logic [1:0] {IDLE, PLAY, WON} state_t;
  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);
  localparam logic [3:0] WIN_VAL  = 4'(WIN_SCORE);
  localparam logic [4:0] MAXP     = 5'(MAX_PENDING);
  state_t state, state_n;
  logic [3:0] score_n, pending, pending_n, frame_cnt, frame_cnt_n;
  logic [4:0] sum;
  logic wrap, step;
  // next-state: gameStart wins over hits and drain steps; a winning step clears leftover points
  always_comb begin
    wrap = startOfFrame && frame_cnt == DIV_LAST;
    step = state == PLAY && wrap && pending != 4'd0;
    sum = {1'b0, pending} + {3'b0, hit ? hitPoints : 2'd0} - {4'b0, step};
    state_n = state;
    score_n = score;
    pending_n = pending;
    frame_cnt_n = frame_cnt;
    if (gameStart) begin
      state_n = PLAY;
      score_n = 4'd0;
      pending_n = 4'd0;
      frame_cnt_n = 4'd0;
    end else if (state == PLAY) begin
      frame_cnt_n = startOfFrame ? (wrap ? 4'd0 : frame_cnt + 4'd1) : frame_cnt;
      score_n = score + {3'b0, step};
      state_n = step && score_n == WIN_VAL ? WON : PLAY;
      pending_n = state_n == WON ? 4'd0 : (sum > MAXP ? MAXP[3:0] : sum[3:0]);
    end
  end
  // state and counter registers
  always_ff @(posedge clk) begin
    if (resetN) begin
      state <= IDLE;
      score <= 4'd0;
      pending <= 4'd0;
      frame_cnt <= 4'd0;
    end else begin
      state <= state_n;
      score <= score_n;
      pending <= pending_n;
      frame_cnt <= frame_cnt_n;
    end
  end
  assign busy = pending != 4'd0;
  assign win  = state == WON;
`ifdef WIN_FLASH_EN
  localparam int FW = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
  logic [FW-1:0] flash_cnt;
  // blink the digit while resting in WON; visible on entry, exit and reset
  always_ff @(posedge clk) begin
    if (resetN || state != WON || state_n != WON) begin
      flash_cnt <= '0;
      scoreVisible <= 1'b1;
    end else if (startOfFrame) begin
      flash_cnt <= flash_cnt == FLASH_LAST ? '0 : flash_cnt + FW'(1);
      scoreVisible <= flash_cnt == FLASH_LAST ? ~scoreVisible : scoreVisible;
    end
  end
`else
  assign scoreVisible = 1'b1;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: table-driven and directed checks for score_keeper
module tb_score_keeper;
  logic clk = 1'b0, resetN = 1'b1, startOfFrame = 1'b0, gameStart = 1'b0, hit = 1'b0;
  logic [1:0] hitPoints = 2'd0;
  logic [3:0] score;
  logic busy, win, scoreVisible;
  int total = 0, passed = 0;

  typedef struct {
    logic rst, gs, sof, ht;
    logic [1:0] hp;
    logic [3:0] sc;
    logic bz, wn;
  } vec_t;
  vec_t vq[$];

  score_keeper dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .gameStart(gameStart),
    .hit(hit), .hitPoints(hitPoints), .score(score), .busy(busy), .win(win),
    .scoreVisible(scoreVisible)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(logic r, logic g, logic s, logic h, logic [1:0] p);
    resetN = r; gameStart = g; startOfFrame = s; hit = h; hitPoints = p;
    @(posedge clk);
    #1;
    resetN = 1'b0; gameStart = 1'b0; startOfFrame = 1'b0; hit = 1'b0; hitPoints = 2'd0;
  endtask

  task automatic frame();
    tick(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic add(int n, logic r, logic g, logic s, logic h, logic [1:0] p,
                     logic [3:0] sc, logic bz, logic wn);
    repeat (n) vq.push_back('{r, g, s, h, p, sc, bz, wn});
  endtask

  initial begin
    int n;
    logic ev;
    add(2, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 3, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 3, 0, 1, 0);
    add(3, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 1, 1, 0);
    add(3, 0, 0, 1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 1, 0, 0, 2, 1, 0);
    add(3, 0, 0, 1, 0, 0, 2, 1, 0);
    add(1, 0, 0, 1, 0, 0, 3, 0, 0);
    add(1, 0, 0, 1, 0, 0, 3, 0, 0);
    add(1, 0, 0, 0, 1, 2, 3, 1, 0);
    add(2, 0, 0, 1, 0, 0, 3, 1, 0);
    add(1, 0, 0, 1, 1, 2, 4, 1, 0);
    add(3, 0, 0, 1, 0, 0, 4, 1, 0);
    add(1, 0, 0, 1, 0, 0, 5, 1, 0);
    add(3, 0, 0, 1, 0, 0, 5, 1, 0);
    add(1, 0, 0, 1, 0, 0, 6, 1, 0);
    add(3, 0, 0, 1, 0, 0, 6, 1, 0);
    add(1, 0, 0, 1, 0, 0, 7, 0, 0);
    add(1, 0, 0, 0, 1, 0, 7, 0, 0);
    add(1, 0, 0, 0, 1, 3, 7, 1, 0);
    add(1, 1, 0, 0, 1, 3, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].rst, vq[i].gs, vq[i].sof, vq[i].ht, vq[i].hp);
      chk($sformatf("row%0d score", i), score, vq[i].sc);
      chk($sformatf("row%0d busy", i), busy, vq[i].bz);
      chk($sformatf("row%0d win", i), win, vq[i].wn);
      chk($sformatf("row%0d visible", i), scoreVisible, 1);
    end

    tick(0, 1, 0, 0, 0);
    repeat (6) tick(0, 0, 0, 1, 3);
    chk("saturated pending", dut.pending, 15);
    chk("saturated busy", busy, 1);
    n = 0;
    while (!win && n < 200) begin
      frame();
      n++;
    end
    chk("frames to win", n, 36);
    chk("win score", score, 9);
    chk("win busy", busy, 0);
    chk("win visible", scoreVisible, 1);
    tick(0, 0, 0, 1, 3);
    chk("won hit busy", busy, 0);
    chk("won hit score", score, 9);
    for (int f = 1; f <= 23; f++) begin
      frame();
`ifdef WIN_FLASH_EN
      ev = !(f >= 8 && f < 16);
`else
      ev = 1'b1;
`endif
      chk($sformatf("flash f%0d visible", f), scoreVisible, ev);
      chk($sformatf("flash f%0d score", f), score, 9);
      chk($sformatf("flash f%0d win", f), win, 1);
    end

    tick(0, 1, 0, 1, 3);
    chk("restart score", score, 0);
    chk("restart busy", busy, 0);
    chk("restart win", win, 0);
    chk("restart visible", scoreVisible, 1);
    repeat (4) frame();
    chk("restart no pending score", score, 0);
    tick(0, 0, 0, 1, 3);
    chk("replay busy", busy, 1);
    repeat (4) frame();
    chk("replay step score", score, 1);
    repeat (3) frame();
    tick(0, 1, 1, 0, 0);
    chk("gs over step score", score, 0);
    chk("gs over step busy", busy, 0);
    repeat (4) frame();
    chk("after gs score", score, 0);
    chk("after gs busy", busy, 0);
    chk("after gs win", win, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Produces the 4-bit decimal score digit consumed by the on-screen score display block.
- Accepts single-cycle hit events carrying 0..3 points and buffers them in a saturating pending-points accumulator.
- Drains the accumulator into the displayed score one point per COUNT_DIV frames, so the digit visibly counts up.
- Runs a small game-state machine (IDLE/PLAY/WON) and asserts a win flag at WIN_SCORE.

Parameters:
- WIN_SCORE, 9, score value that ends the game; legal range 1..9.
- COUNT_DIV, 4, number of startOfFrame pulses per one-point drain step; legal range 1..15.
- MAX_PENDING, 15, saturation ceiling of the pending accumulator (4-bit register).
- FLASH_FRAMES, 8, frames per visibility toggle in WON; used only with WIN_FLASH_EN.

Ports:
- clk  input  1  system clock; sole clock domain.
- resetN  input  1  synchronous, active-high reset (1 = reset), sampled on rising clk.
- startOfFrame  input  1  one-cycle pulse, once per video frame.
- gameStart  input  1  one-cycle pulse; starts a new game.
- hit  input  1  one-cycle pulse; the ball scored.
- hitPoints  input  2  points for this hit, 0..3; valid only when hit=1.
- score  output  4  current score digit 0..9; feeds the display block.
- busy  output  1  high while pending != 0.
- win  output  1  high in state WON.
- scoreVisible  output  1  display enable for the score digit.

Behaviour:
- Reset is synchronous and active-high. One clock only.
- Values while resetN=1:
  - state=IDLE; score=0; pending=0; frameCnt=0; flashCnt=0.
  - win=0; busy=0; scoreVisible=1.
- Reset asserted mid-game or mid-count abandons all pending points.
- All outputs are registered. busy and win are decoded from registered state/pending, with no combinational path from inputs.
- State IDLE:
  - hit and startOfFrame are ignored.
  - gameStart -> PLAY, with score=0, pending=0, frameCnt=0.
- State PLAY, accumulate:
  - On hit, pending <= min(pending + hitPoints, MAX_PENDING).
  - hitPoints=0 is legal and leaves pending unchanged.
- State PLAY, drain:
  - Each startOfFrame increments frameCnt.
  - When frameCnt==COUNT_DIV-1 on a startOfFrame, frameCnt <= 0. If pending>0 in that cycle, then score <= score+1 and pending <= pending-1.
  - The first step occurs on the COUNT_DIV-th startOfFrame after gameStart.
  - The new score is visible the cycle after that startOfFrame.
- Simultaneous hit and drain step in the same cycle: pending <= min(pending + hitPoints - 1, MAX_PENDING). No point is lost or double-counted.
- Win transition:
  - A drain step that makes score == WIN_SCORE moves the state to WON in the same edge; win=1 from the next cycle.
  - Remaining pending is cleared to 0.
- State WON:
  - score is held; hit is ignored.
  - gameStart -> PLAY with score=0, pending=0, frameCnt=0, win=0.
- gameStart together with hit or a drain step: gameStart has priority, and the hit and the step are discarded.
- Arithmetic:
  - score never exceeds WIN_SCORE and never wraps.
  - pending is computed 5 bits wide before saturation.

Optional Feature:
- Macro: WIN_FLASH_EN.
- Defined:
  - In WON, flashCnt counts startOfFrame pulses modulo FLASH_FRAMES.
  - scoreVisible toggles when flashCnt wraps.
  - Entering WON sets scoreVisible=1 and flashCnt=0.
  - Leaving WON (gameStart or reset) forces scoreVisible=1.
- Undefined: flashCnt is not implemented and scoreVisible is tied to 1.

Test Plan:
- Reset/IDLE: drive resetN=1 for 2 cycles, then hit with hitPoints=3 before gameStart -> score=0, busy=0, win=0 throughout.
- Basic count with COUNT_DIV=4: gameStart, then hit with hitPoints=3 -> busy=1.
  - score steps 1, 2, 3 on startOfFrame numbers 4, 8 and 12.
  - busy=0 after the 12th pulse.
- Saturation: six hits with hitPoints=3 in consecutive cycles -> pending=15, not 18. Score eventually reaches 9, win=1, pending cleared.
- Simultaneous hit and drain: with pending=2, hit with hitPoints=2 coincides with the drain step -> score+1 and pending=3.
- Restart priority: in WON with score=9, gameStart coincides with hit of 3 -> next cycle score=0, pending=0, win=0, state PLAY.
- Flash (with WIN_FLASH_EN, FLASH_FRAMES=8): after win, scoreVisible is low for frames 8..15 and high for frames 16..23. With the macro undefined, scoreVisible is constantly 1.
